// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared FSM states, controller request codes and id-width helper for the SDRAM arbiter
package sdram_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
    localparam logic [1:0] REQ_IDLE = 2'b00;
    localparam logic [1:0] REQ_RD   = 2'b01;
    localparam logic [1:0] REQ_WR   = 2'b10;
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sdram_rw_arbiter_rr_if.sv
// sdram_rw_arbiter_rr_if: requester and controller-side signals of the SDRAM round-robin arbiter
interface sdram_rw_arbiter_rr_if
    import sdram_arb_pkg::*;
#(
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 3,
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16,
    parameter int BURST  = 4
);
    localparam int IW = id_w(NUM_RD + NUM_WR);
    logic                            i_excl;
    logic [NUM_RD-1:0]               i_rd_req;
    logic [NUM_RD*ADDR_W-1:0]        i_rd_addr;
    logic [NUM_RD-1:0]               o_rd_done;
    logic [BURST*DATA_W-1:0]         o_rd_data;
    logic [NUM_WR-1:0]               i_wr_req;
    logic [NUM_WR*ADDR_W-1:0]        i_wr_addr;
    logic [NUM_WR*BURST*DATA_W-1:0]  i_wr_data;
    logic [NUM_WR-1:0]               o_wr_done;
    logic [1:0]                      o_ctrl_req;
    logic [ADDR_W-1:0]               o_ctrl_addr;
    logic [BURST*DATA_W-1:0]         o_ctrl_wdata;
    logic [BURST*DATA_W-1:0]         i_ctrl_rdata;
    logic [1:0]                      i_ctrl_done;
    logic                            o_busy;
    logic [IW-1:0]                   o_grant_id;
    logic                            o_timeout;

    modport slave (
        input  i_excl, i_rd_req, i_rd_addr, i_wr_req, i_wr_addr, i_wr_data, i_ctrl_rdata, i_ctrl_done,
        output o_rd_done, o_rd_data, o_wr_done, o_ctrl_req, o_ctrl_addr, o_ctrl_wdata, o_busy, o_grant_id, o_timeout
    );
    modport master (
        output i_excl, i_rd_req, i_rd_addr, i_wr_req, i_wr_addr, i_wr_data, i_ctrl_rdata, i_ctrl_done,
        input  o_rd_done, o_rd_data, o_wr_done, o_ctrl_req, o_ctrl_addr, o_ctrl_wdata, o_busy, o_grant_id, o_timeout
    );
endinterface

// File: rtl/sdram_arb_rr_pick.sv
// sdram_arb_rr_pick: combinational round-robin picker, first set request searching from ptr+1 mod N
module sdram_arb_rr_pick #(
    parameter int N  = 5,
    parameter int IW = 3
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_valid,
    output logic [IW-1:0] o_id
);
    always_comb begin
        logic [IW-1:0] w_idx;
        w_idx   = '0;
        o_valid = |i_req;
        o_id    = '0;
        // walk from the farthest candidate back so the nearest one after ptr wins
        for (int i = N; i >= 1; i--) begin
            w_idx = IW'((int'(i_ptr) + i) % N);
            if (i_req[w_idx]) o_id = w_idx;
        end
    end
endmodule

// File: rtl/sdram_rw_arbiter_rr.sv
// sdram_rw_arbiter_rr: fair N-read/M-write arbiter onto one 4-word-burst SDRAM controller port.
// Optional BUSY watchdog enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_rw_arbiter_rr
    import sdram_arb_pkg::*;
#(
    parameter int NUM_RD      = 2,
    parameter int NUM_WR      = 3,
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 16,
    parameter int BURST       = 4,
    parameter int EXCL_WR_IDX = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    sdram_rw_arbiter_rr_if.slave bus
);
    localparam int N  = NUM_RD + NUM_WR;
    localparam int IW = id_w(N);
    localparam int BW = BURST * DATA_W;

    state_t            r_state, w_state_nx;
    logic [IW-1:0]     r_ptr, r_id, w_pick_id;
    logic [N-1:0]      r_mask, w_all, w_elig, w_ack_oh;
    logic [1:0]        r_ctrl_req;
    logic [ADDR_W-1:0] r_addr;
    logic [BW-1:0]     r_wdata, r_rd_data;
    logic              w_pick_vld, w_grant, w_done, w_tmo, w_is_rd;
    int                w_rd_k, w_wr_k;

    assign w_all  = {bus.i_wr_req, bus.i_rd_req};
    assign w_elig = (bus.i_excl ? (N'(1) << (NUM_RD + EXCL_WR_IDX)) & w_all : w_all) & ~r_mask;

    sdram_arb_rr_pick #(.N(N), .IW(IW)) u_pick (
        .i_req   (w_elig),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_vld),
        .o_id    (w_pick_id)
    );

    assign w_grant = (r_state == IDLE) && en && w_pick_vld;
    assign w_is_rd = int'(w_pick_id) < NUM_RD;
    assign w_rd_k  = w_is_rd ? int'(w_pick_id) : 0;
    assign w_wr_k  = w_is_rd ? 0 : int'(w_pick_id) - NUM_RD;
    // only the done bit of the op in flight counts
    assign w_done  = (r_state == BUSY) && |(bus.i_ctrl_done & r_ctrl_req);

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);
    logic [CW-1:0] r_cnt;
    logic          r_timeout;
    assign w_tmo = (r_state == BUSY) && !w_done && (r_cnt == TMO_LAST);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt     <= (r_state == BUSY) ? r_cnt + 1'b1 : '0;
            r_timeout <= w_tmo;
        end
    end
    assign bus.o_timeout = r_timeout;
`else
    assign w_tmo         = 1'b0;
    assign bus.o_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_state_nx = (r_state == IDLE) ? (w_grant ? BUSY : IDLE) :
                     (r_state == BUSY) ? (w_done ? ACK : (w_tmo ? IDLE : BUSY)) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= IW'(N - 1);
            r_mask     <= '0;
            r_id       <= '0;
            r_ctrl_req <= REQ_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd_data  <= '0;
        end else begin
            if (r_state == IDLE) r_mask <= '0;
            if (w_grant) begin
                r_id       <= w_pick_id;
                r_ptr      <= w_pick_id;
                r_ctrl_req <= w_is_rd ? REQ_RD : REQ_WR;
                r_addr     <= w_is_rd ? bus.i_rd_addr[w_rd_k*ADDR_W +: ADDR_W]
                                      : bus.i_wr_addr[w_wr_k*ADDR_W +: ADDR_W];
                r_wdata    <= w_is_rd ? '0 : bus.i_wr_data[w_wr_k*BW +: BW];
            end
            if (w_done || w_tmo) r_ctrl_req <= REQ_IDLE;
            if (w_done && r_ctrl_req == REQ_RD) r_rd_data <= bus.i_ctrl_rdata;
            // keep the just-served port out of the following IDLE cycle while it drops req
            if (r_state == ACK) r_mask <= N'(1) << r_id;
        end
    end

    assign w_ack_oh         = (r_state == ACK) ? N'(1) << r_id : '0;
    assign bus.o_rd_done    = w_ack_oh[NUM_RD-1:0];
    assign bus.o_wr_done    = w_ack_oh[N-1:NUM_RD];
    assign bus.o_rd_data    = r_rd_data;
    assign bus.o_ctrl_req   = r_ctrl_req;
    assign bus.o_ctrl_addr  = r_addr;
    assign bus.o_ctrl_wdata = r_wdata;
    assign bus.o_busy       = r_state != IDLE;
    assign bus.o_grant_id   = r_id;
endmodule

// File: tb/tb_sdram_rw_arbiter_rr.sv
// tb_sdram_rw_arbiter_rr: directed self-checking bench for the SDRAM round-robin arbiter.
// Timeout scenario compiled in only when SDRAM_ARB_TIMEOUT_EN is defined.
module tb_sdram_rw_arbiter_rr;
    localparam int NUM_RD = 2;
    localparam int NUM_WR = 3;

    logic clk, rst, en;
    int   n_chk, n_fail;

    sdram_rw_arbiter_rr_if bus ();

    sdram_rw_arbiter_rr dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [23:0] exp_addr(input int id);
        return (id < NUM_RD) ? 24'h000100 * 24'(id + 1) : 24'hA00000 + 24'(id);
    endfunction

    function automatic logic [63:0] exp_wdata(input int id);
        return 64'h4400_3300_2200_1100 + 64'(id);
    endfunction

    function automatic logic [63:0] exp_rdata(input int id);
        return 64'h8888_7777_6666_5550 + 64'(id);
    endfunction

    task automatic wait_req();
        int k;
        k = 0;
        while (bus.o_ctrl_req == 2'b00 && k < 50) begin
            tick();
            k++;
        end
        chk("wait_req_in_budget", 64'(k < 50), 64'd1);
    endtask

    task automatic serve(input int id);
        logic [1:0] op;
        op = (id < NUM_RD) ? 2'b01 : 2'b10;
        wait_req();
        chk("grant_id", 64'(bus.o_grant_id), 64'(id));
        chk("ctrl_req", 64'(bus.o_ctrl_req), 64'(op));
        chk("ctrl_addr", 64'(bus.o_ctrl_addr), 64'(exp_addr(id)));
        if (op == 2'b10) chk("ctrl_wdata", bus.o_ctrl_wdata, exp_wdata(id));
        bus.i_ctrl_rdata = exp_rdata(id);
        bus.i_ctrl_done  = op;
        tick();
        bus.i_ctrl_done  = 2'b00;
        chk("done_onehot", 64'({bus.o_wr_done, bus.o_rd_done}), 64'(5'b1 << id));
        if (op == 2'b01) chk("rd_data", bus.o_rd_data, exp_rdata(id));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_ctrl_req", 64'(bus.o_ctrl_req), 64'd0);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_grant_id", 64'(bus.o_grant_id), 64'd0);
        chk("rst_done", 64'({bus.o_wr_done, bus.o_rd_done}), 64'd0);
        chk("rst_rd_data", bus.o_rd_data, 64'd0);
        chk("rst_timeout", 64'(bus.o_timeout), 64'd0);
        rst = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        en = 1'b1;
        bus.i_excl = 1'b0;
        bus.i_rd_req = '0;
        bus.i_wr_req = '0;
        bus.i_rd_addr = {exp_addr(1), exp_addr(0)};
        bus.i_wr_addr = {exp_addr(4), exp_addr(3), exp_addr(2)};
        bus.i_wr_data = {exp_wdata(4), exp_wdata(3), exp_wdata(2)};
        bus.i_ctrl_rdata = '0;
        bus.i_ctrl_done = 2'b00;
        do_reset();

        // single read on port 0
        bus.i_rd_req = 2'b01;
        tick();
        chk("t1_req_latency", 64'(bus.o_ctrl_req), 64'h1);
        chk("t1_addr", 64'(bus.o_ctrl_addr), 64'h000100);
        chk("t1_busy", 64'(bus.o_busy), 64'd1);
        bus.i_ctrl_rdata = 64'h4444_3333_2222_1111;
        bus.i_ctrl_done = 2'b01;
        tick();
        bus.i_ctrl_done = 2'b00;
        chk("t1_rd_done", 64'(bus.o_rd_done), 64'h1);
        chk("t1_rd_data", bus.o_rd_data, 64'h4444_3333_2222_1111);
        chk("t1_req_dropped", 64'(bus.o_ctrl_req), 64'd0);
        bus.i_rd_req = 2'b00;
        tick();
        chk("t1_done_1cyc", 64'(bus.o_rd_done), 64'd0);
        chk("t1_idle", 64'(bus.o_busy), 64'd0);

        // all five requesters held: round-robin order
        do_reset();
        bus.i_rd_req = 2'b11;
        bus.i_wr_req = 3'b111;
        for (int g = 0; g < 10; g++) serve(g % 5);

        // exclusive mode: only write port 2 (id 4)
        bus.i_excl = 1'b1;
        for (int g = 0; g < 3; g++) serve(4);
        bus.i_excl = 1'b0;
        serve(0);

        // en dropped mid write burst
        bus.i_rd_req = 2'b00;
        bus.i_wr_req = 3'b001;
        wait_req();
        chk("t4_grant_id", 64'(bus.o_grant_id), 64'd2);
        chk("t4_ctrl_req", 64'(bus.o_ctrl_req), 64'h2);
        tick();
        tick();
        en = 1'b0;
        bus.i_rd_req = 2'b01;
        tick();
        chk("t4_burst_held", 64'(bus.o_ctrl_req), 64'h2);
        bus.i_ctrl_done = 2'b10;
        tick();
        bus.i_ctrl_done = 2'b00;
        chk("t4_wr_done", 64'({bus.o_wr_done, bus.o_rd_done}), 64'b00100);
        bus.i_wr_req = 3'b000;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t4_no_grant_en0", 64'({bus.o_busy, bus.o_ctrl_req}), 64'd0);
        end
        en = 1'b1;

        // wrong done bit during a read is ignored
        wait_req();
        chk("t5_grant_id", 64'(bus.o_grant_id), 64'd0);
        chk("t5_ctrl_req", 64'(bus.o_ctrl_req), 64'h1);
        bus.i_ctrl_done = 2'b10;
        tick();
        tick();
        chk("t5_ignored_req", 64'(bus.o_ctrl_req), 64'h1);
        chk("t5_ignored_done", 64'({bus.o_wr_done, bus.o_rd_done}), 64'd0);
        chk("t5_still_busy", 64'(bus.o_busy), 64'd1);
        bus.i_ctrl_rdata = 64'hDEAD_BEEF_0123_4567;
        bus.i_ctrl_done = 2'b01;
        tick();
        bus.i_ctrl_done = 2'b00;
        chk("t5_rd_done", 64'(bus.o_rd_done), 64'h1);
        chk("t5_rd_data", bus.o_rd_data, 64'hDEAD_BEEF_0123_4567);
        bus.i_rd_req = 2'b00;

        // reset in the middle of a burst
        bus.i_wr_req = 3'b100;
        wait_req();
        chk("t6_grant_id", 64'(bus.o_grant_id), 64'd4);
        tick();
        rst = 1'b1;
        tick();
        chk("t6_rst_req", 64'(bus.o_ctrl_req), 64'd0);
        chk("t6_rst_busy", 64'(bus.o_busy), 64'd0);
        chk("t6_rst_done", 64'({bus.o_wr_done, bus.o_rd_done}), 64'd0);
        rst = 1'b0;
        bus.i_wr_req = 3'b000;
        tick();
        chk("t6_no_done_after", 64'({bus.o_wr_done, bus.o_rd_done}), 64'd0);

`ifdef SDRAM_ARB_TIMEOUT_EN
        begin
            int k;
            bus.i_rd_req = 2'b10;
            wait_req();
            chk("tmo_grant_id", 64'(bus.o_grant_id), 64'd1);
            k = 0;
            while (!bus.o_timeout && k < 1100) begin
                tick();
                k++;
            end
            chk("tmo_cycles", 64'(k), 64'd1024);
            chk("tmo_req_dropped", 64'(bus.o_ctrl_req), 64'd0);
            chk("tmo_no_done", 64'({bus.o_wr_done, bus.o_rd_done}), 64'd0);
            serve(1);
            bus.i_rd_req = 2'b00;
        end
`else
        chk("no_timeout_flag", 64'(bus.o_timeout), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
